// File: rtl/stencil_pkg.sv
// Shared definitions for the Stencil run sequencer: state encoding,
// Lite register word indices and CTRL/STATUS bit positions.
package stencil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COEFF   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_EOF     = 3'd4,
    ST_RECOVER = 3'd5
  } state_e;

  // Register word indices (byte address bits [4:2]).
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_OUT_LEN   = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_OUT_COUNT = 3'd3;
  localparam logic [2:0] REG_CYCLES    = 3'd4;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;
  localparam int STATUS_DONE_BIT  = 3;
  localparam int STATUS_ERR_BIT   = 4;
  localparam int STATUS_SHORT_BIT = 5;

  // States in which Stencil is actively running and the cycle counter ticks.
  function automatic logic is_active(state_e s);
    return (s == ST_COEFF) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/stencil_run_ctrl_if.sv
// Xillybus Lite register bus (user_clk is the same clock as bus_clk).
interface stencil_run_ctrl_if;
  logic        wren;
  logic        rden;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output wren, rden, addr, wr_data, input rd_data);
  modport slave  (input wren, rden, addr, wr_data, output rd_data);
endinterface

// File: rtl/stencil_ctrl_regs.sv
// Lite register block: CTRL/OUT_LEN/STATUS storage, start/abort pulses,
// sticky status bits and the registered read mux.
module stencil_ctrl_regs
  import stencil_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stencil_run_ctrl_if.slave    bus,
  input  state_e               state,
  input  logic [CNT_W-1:0]     out_count,
  input  logic [CNT_W-1:0]     cycles,
  input  logic                 set_done,
  input  logic                 set_err,
  input  logic                 set_short,
  output logic                 start,
  output logic                 abort,
  output logic [CNT_W-1:0]     out_len,
  output logic                 irq
);

  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] out_len_q, out_len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             short_q, short_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      rd_word;
  logic [2:0]       idx;
  logic             wr_ctrl, wr_len, wr_status;
  logic             unused_addr_lsb;

  assign idx             = bus.addr[4:2];
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Write decode, W1 pulses, W1C sticky status and read mux.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    wr_ctrl   = bus.wren && (idx == REG_CTRL);
    wr_len    = bus.wren && (idx == REG_OUT_LEN);
    wr_status = bus.wren && (idx == REG_STATUS);

    start = wr_ctrl && bus.wr_data[CTRL_START_BIT];
    abort = wr_ctrl && bus.wr_data[CTRL_ABORT_BIT];

    irq_en_d  = wr_ctrl ? bus.wr_data[CTRL_IRQ_EN_BIT] : irq_en_q;
    out_len_d = wr_len ? bus.wr_data[CNT_W-1:0] : out_len_q;

    // A hardware set in the same cycle as a host clear wins.
    done_d  = (done_q  && !(wr_status && bus.wr_data[STATUS_DONE_BIT]))  || set_done;
    err_d   = (err_q   && !(wr_status && bus.wr_data[STATUS_ERR_BIT]))   || set_err;
    short_d = (short_q && !(wr_status && bus.wr_data[STATUS_SHORT_BIT])) || set_short;

    rd_word = '0;
    unique case (idx)
      REG_CTRL:      rd_word = {29'd0, irq_en_q, 2'b00};
      REG_OUT_LEN:   rd_word = 32'(out_len_q);
      REG_STATUS:    rd_word = {26'd0, short_q, err_q, done_q, state};
      REG_OUT_COUNT: rd_word = 32'(out_count);
      REG_CYCLES:    rd_word = 32'(cycles);
      default:       rd_word = '0;
    endcase
    // Read data captures pre-write register contents and holds between reads.
    rd_data_d = bus.rden ? rd_word : rd_data_q;
  end

  // Register state; all control/status flops cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q  <= 1'b0;
      out_len_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      short_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      irq_en_q  <= irq_en_d;
      out_len_q <= out_len_d;
      done_q    <= done_d;
      err_q     <= err_d;
      short_q   <= short_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign out_len     = out_len_q;
  assign irq         = done_q && irq_en_q;

endmodule

// File: rtl/stencil_run_ctrl.sv
// Run sequencer between the Xillybus FIFOs and Stencil: gates FIFO flags so
// coefficients precede data, counts outputs, drives Stencil reset and EOF.
module stencil_run_ctrl
  import stencil_pkg::*;
#(
  parameter int NUM_COEFF  = 9,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wren,
  input  logic        cfg_rden,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wr_data,
  output logic [31:0] cfg_rd_data,
  input  logic        host_in_open,
  input  logic        host_out_open,
  input  logic        host_out_empty,
  input  logic        coeff_empty_raw,
  input  logic        in_empty_raw,
  input  logic        out_full_raw,
  output logic        coeff_empty_g,
  output logic        in_empty_g,
  output logic        out_full_g,
  input  logic        stc_coeff_rd_en,
  input  logic        stc_out_wr_en,
  input  logic        stc_done,
  output logic        stc_reset,
  output logic        eof,
  output logic        irq
);

  localparam int CW   = $clog2(NUM_COEFF + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]    coeff_cnt_q, coeff_cnt_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] out_len;
  logic             start, abort;
  logic             set_done, set_err, set_short;
  logic             coeff_rd, out_wr;

  stencil_run_ctrl_if lite ();

  assign lite.wren    = cfg_wren;
  assign lite.rden    = cfg_rden;
  assign lite.addr    = cfg_addr;
  assign lite.wr_data = cfg_wr_data;
  assign cfg_rd_data  = lite.rd_data;

  stencil_ctrl_regs #(.CNT_W(CNT_W)) u_regs (
    .clk       (clk),
    .rst_n     (reset_n),
    .bus       (lite.slave),
    .state     (state_q),
    .out_count (out_count_q),
    .cycles    (cycles_q),
    .set_done  (set_done),
    .set_err   (set_err),
    .set_short (set_short),
    .start     (start),
    .abort     (abort),
    .out_len   (out_len),
    .irq       (irq)
  );

  assign coeff_rd = stc_coeff_rd_en && !coeff_empty_raw;
  // The length guard keeps OUT_COUNT within OUT_LEN even if the host rewrites it mid-run.
  assign out_wr   = stc_out_wr_en && !out_full_raw && (out_count_q < out_len);

  // State register and run counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RECOVER;
      rst_cnt_q   <= RST_LOAD;
      coeff_cnt_q <= '0;
      out_count_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      coeff_cnt_q <= coeff_cnt_d;
      out_count_q <= out_count_d;
      cycles_q    <= cycles_d;
    end
  end

  // Next-state, counter updates and status set pulses.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    coeff_cnt_d = coeff_cnt_q;
    out_count_d = out_count_q;
    cycles_d    = cycles_q;
    set_done    = 1'b0;
    set_err     = 1'b0;
    set_short   = 1'b0;

    if (is_active(state_q) && (cycles_q != '1)) cycles_d = cycles_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Abort wins over a simultaneous start.
        if (start && !abort) begin
          if ((out_len != '0) && host_in_open && host_out_open) begin
            state_d     = ST_COEFF;
            coeff_cnt_d = '0;
            out_count_d = '0;
            cycles_d    = '0;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_COEFF: begin
        if (coeff_rd) begin
          coeff_cnt_d = coeff_cnt_q + 1'b1;
          if (coeff_cnt_q == CW'(NUM_COEFF - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_wr) out_count_d = out_count_q + 1'b1;
        if (out_wr && ((out_count_q + 1'b1) == out_len)) begin
          state_d = ST_DRAIN;
        end else if (stc_done) begin
          state_d   = ST_DRAIN;
          set_short = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (host_out_empty) begin
          state_d  = ST_EOF;
          set_done = 1'b1;
        end
      end
      ST_EOF: begin
        if (!host_out_open) begin
          state_d   = ST_RECOVER;
          rst_cnt_d = RST_LOAD;
        end
      end
      ST_RECOVER: begin
        if (rst_cnt_q == '0) state_d = ST_IDLE;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      default: begin
        state_d   = ST_RECOVER;
        rst_cnt_d = RST_LOAD;
      end
    endcase

    // Abort or a device closing mid-run overrides any other transition.
    if (is_active(state_q) && (abort || !host_in_open || !host_out_open)) begin
      state_d   = ST_RECOVER;
      rst_cnt_d = RST_LOAD;
      set_err   = 1'b1;
      set_done  = 1'b0;
      set_short = 1'b0;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    stc_reset     = 1'b1;
    coeff_empty_g = 1'b1;
    in_empty_g    = 1'b1;
    out_full_g    = 1'b1;
    eof           = 1'b0;
    unique case (state_q)
      ST_COEFF: begin
        stc_reset     = 1'b0;
        coeff_empty_g = coeff_empty_raw;
        out_full_g    = out_full_raw;
      end
      ST_RUN: begin
        stc_reset  = 1'b0;
        in_empty_g = in_empty_raw;
        out_full_g = out_full_raw;
      end
      ST_DRAIN: stc_reset = 1'b0;
      ST_EOF: begin
        stc_reset = 1'b0;
        eof       = 1'b1;
      end
      default: stc_reset = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_stencil_run_ctrl.sv
// Directed bench for stencil_run_ctrl (NUM_COEFF=9, RST_CYCLES=4).
module tb_stencil_run_ctrl;

  localparam logic [4:0] A_CTRL      = 5'h00;
  localparam logic [4:0] A_OUT_LEN   = 5'h04;
  localparam logic [4:0] A_STATUS    = 5'h08;
  localparam logic [4:0] A_OUT_COUNT = 5'h0C;
  localparam logic [4:0] A_CYCLES    = 5'h10;

  logic clk = 1'b0;
  logic reset_n;
  logic host_in_open, host_out_open, host_out_empty;
  logic coeff_empty_raw, in_empty_raw, out_full_raw;
  logic coeff_empty_g, in_empty_g, out_full_g;
  logic stc_coeff_rd_en, stc_out_wr_en, stc_done;
  logic stc_reset, eof, irq;

  int tests_run    = 0;
  int tests_failed = 0;

  stencil_run_ctrl_if lite ();

  always #5 clk = ~clk;

  stencil_run_ctrl #(.NUM_COEFF(9), .CNT_W(32), .RST_CYCLES(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_wren        (lite.wren),
    .cfg_rden        (lite.rden),
    .cfg_addr        (lite.addr),
    .cfg_wr_data     (lite.wr_data),
    .cfg_rd_data     (lite.rd_data),
    .host_in_open    (host_in_open),
    .host_out_open   (host_out_open),
    .host_out_empty  (host_out_empty),
    .coeff_empty_raw (coeff_empty_raw),
    .in_empty_raw    (in_empty_raw),
    .out_full_raw    (out_full_raw),
    .coeff_empty_g   (coeff_empty_g),
    .in_empty_g      (in_empty_g),
    .out_full_g      (out_full_g),
    .stc_coeff_rd_en (stc_coeff_rd_en),
    .stc_out_wr_en   (stc_out_wr_en),
    .stc_done        (stc_done),
    .stc_reset       (stc_reset),
    .eof             (eof),
    .irq             (irq)
  );

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    lite.wren = 1'b1; lite.addr = a; lite.wr_data = d;
    @(negedge clk);
    lite.wren = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    lite.rden = 1'b1; lite.addr = a;
    @(negedge clk);
    lite.rden = 1'b0;
    d = lite.rd_data;
  endtask

  // Behaves like Stencil: reads coeff/in whenever the gated flag allows and
  // writes one output per data cycle until 'limit' outputs were written.
  task automatic run_stencil(input int limit, output int coeff_at_in,
                             output int writes, output bit timed_out);
    int coeff_reads;
    coeff_reads = 0; coeff_at_in = -1; writes = 0; timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (writes == limit) begin
        timed_out = 1'b0;
        break;
      end
      stc_coeff_rd_en = !coeff_empty_g;
      if (!coeff_empty_g) coeff_reads++;
      if (!in_empty_g && coeff_at_in < 0) coeff_at_in = coeff_reads;
      stc_out_wr_en = !in_empty_g && !out_full_g;
      if (stc_out_wr_en) writes++;
    end
    stc_coeff_rd_en = 1'b0;
    stc_out_wr_en   = 1'b0;
  endtask

  // Host closes the read device to leave EOF, then waits for IDLE.
  task automatic end_run();
    logic [31:0] d;
    @(negedge clk);
    host_out_open = 1'b0;
    repeat (6) @(negedge clk);
    host_out_open  = 1'b1;
    host_out_empty = 1'b0;
    cfg_read(A_STATUS, d);
    tests_run++;
    if (d[2:0] !== 3'd0) begin
      tests_failed++;
      $display("FAIL end_run_idle: state=%0d expected 0", d[2:0]);
    end
    cfg_write(A_STATUS, 32'h38);
  endtask

  task automatic test_reset();
    logic [3:0] flags;
    #3;
    flags = {stc_reset, coeff_empty_g, in_empty_g, out_full_g};
    tests_run++;
    if (flags !== 4'hF || eof !== 1'b0 || irq !== 1'b0 || lite.rd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rst/flags=%b eof=%b irq=%b rd=%h expected 1111 0 0 0",
               flags, eof, irq, lite.rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    lite.rden = 1'b1; lite.addr = A_STATUS;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (lite.rd_data !== ((k <= 4) ? 32'h5 : 32'h0) || stc_reset !== 1'b1 || eof !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_recover_cycle%0d: status=%h stc_reset=%b eof=%b expected %h 1 0",
                 k, lite.rd_data, stc_reset, eof, (k <= 4) ? 32'h5 : 32'h0);
      end
    end
    lite.rden = 1'b0;
  endtask

  task automatic test_full_run();
    int coeff_at_in, writes;
    bit to;
    logic [31:0] d;
    cfg_write(A_OUT_LEN, 32'd16);
    cfg_write(A_CTRL, 32'h1);
    run_stencil(16, coeff_at_in, writes, to);
    tests_run++;
    if (to !== 1'b0 || coeff_at_in != 9 || writes != 16) begin
      tests_failed++;
      $display("FAIL run_order: timeout=%b coeff_before_in=%0d writes=%0d expected 0 9 16",
               to, coeff_at_in, writes);
    end
    tests_run++;
    if (out_full_g !== 1'b1 || in_empty_g !== 1'b1 || coeff_empty_g !== 1'b1 || stc_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_flags: full=%b in_empty=%b coeff_empty=%b rst=%b expected 1 1 1 0",
               out_full_g, in_empty_g, coeff_empty_g, stc_reset);
    end
    // Stencil tries to push a 17th word while the gated full flag is up.
    stc_out_wr_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stc_out_wr_en = 1'b0;
    tests_run++;
    if (eof !== 1'b0) begin
      tests_failed++;
      $display("FAIL eof_early: eof=%b expected 0", eof);
    end
    host_out_empty = 1'b1;
    @(negedge clk);
    tests_run++;
    if (eof !== 1'b1 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL eof_latency: eof=%b irq=%b expected 1 0", eof, irq);
    end
    cfg_read(A_OUT_COUNT, d);
    tests_run++;
    if (d !== 32'd16) begin
      tests_failed++;
      $display("FAIL out_count_17th: got %0d expected 16", d);
    end
    cfg_read(A_CYCLES, d);
    tests_run++;
    if (d !== 32'd29) begin
      tests_failed++;
      $display("FAIL cycles: got %0d expected 29", d);
    end
    cfg_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0C) begin
      tests_failed++;
      $display("FAIL status_done: got %h expected 0000000c", d);
    end
    end_run();
  endtask

  task automatic test_start_errors();
    logic [31:0] d;
    tests_run++;
    if (coeff_empty_g !== 1'b1 || in_empty_g !== 1'b1 || out_full_g !== 1'b1 || stc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_gating: %b%b%b rst=%b expected 111 1",
               coeff_empty_g, in_empty_g, out_full_g, stc_reset);
    end
    cfg_write(A_OUT_LEN, 32'd0);
    cfg_write(A_CTRL, 32'h1);
    cfg_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h10 || stc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_len0: status=%h rst=%b expected 00000010 1", d, stc_reset);
    end
    cfg_write(A_STATUS, 32'h38);
    cfg_write(A_OUT_LEN, 32'd16);
    host_in_open = 1'b0;
    cfg_write(A_CTRL, 32'h1);
    cfg_read(A_STATUS, d);
    host_in_open = 1'b1;
    tests_run++;
    if (d !== 32'h10) begin
      tests_failed++;
      $display("FAIL start_closed: status=%h expected 00000010", d);
    end
    cfg_write(A_STATUS, 32'h38);
    cfg_write(A_CTRL, 32'h3);
    cfg_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0 || stc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_abort: status=%h rst=%b expected 00000000 1", d, stc_reset);
    end
  endtask

  task automatic test_abort();
    int coeff_at_in, writes;
    bit to;
    logic [31:0] d;
    cfg_write(A_CTRL, 32'h1);
    run_stencil(5, coeff_at_in, writes, to);
    cfg_read(A_OUT_COUNT, d);
    tests_run++;
    if (to !== 1'b0 || d !== 32'd5) begin
      tests_failed++;
      $display("FAIL abort_pre_count: timeout=%b count=%0d expected 0 5", to, d);
    end
    cfg_write(A_CTRL, 32'h2);
    tests_run++;
    if (stc_reset !== 1'b1 || in_empty_g !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_reset: rst=%b in_empty=%b expected 1 1", stc_reset, in_empty_g);
    end
    lite.rden = 1'b1; lite.addr = A_STATUS;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (lite.rd_data !== ((k <= 4) ? 32'h15 : 32'h10)) begin
        tests_failed++;
        $display("FAIL abort_recover_cycle%0d: status=%h expected %h",
                 k, lite.rd_data, (k <= 4) ? 32'h15 : 32'h10);
      end
    end
    lite.rden = 1'b0;
    cfg_write(A_STATUS, 32'h38);
  endtask

  task automatic test_short();
    int coeff_at_in, writes;
    bit to;
    logic [31:0] d;
    cfg_write(A_CTRL, 32'h4);
    cfg_write(A_CTRL, 32'h5);
    run_stencil(10, coeff_at_in, writes, to);
    stc_done = 1'b1;
    @(negedge clk);
    stc_done = 1'b0;
    tests_run++;
    if (to !== 1'b0 || out_full_g !== 1'b1 || in_empty_g !== 1'b1 || eof !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_drain: timeout=%b full=%b in_empty=%b eof=%b expected 0 1 1 0",
               to, out_full_g, in_empty_g, eof);
    end
    host_out_empty = 1'b1;
    @(negedge clk);
    tests_run++;
    if (eof !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_eof: eof=%b irq=%b expected 1 1", eof, irq);
    end
    cfg_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h2C) begin
      tests_failed++;
      $display("FAIL short_status: got %h expected 0000002c", d);
    end
    cfg_read(A_OUT_COUNT, d);
    tests_run++;
    if (d !== 32'd10) begin
      tests_failed++;
      $display("FAIL short_count: got %0d expected 10", d);
    end
    cfg_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL ctrl_readback: got %h expected 00000004", d);
    end
    cfg_write(A_STATUS, 32'h08);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
    end_run();
  endtask

  initial begin
    reset_n = 1'b1;
    lite.wren = 1'b0; lite.rden = 1'b0; lite.addr = '0; lite.wr_data = '0;
    host_in_open = 1'b1; host_out_open = 1'b1; host_out_empty = 1'b0;
    coeff_empty_raw = 1'b0; in_empty_raw = 1'b0; out_full_raw = 1'b0;
    stc_coeff_rd_en = 1'b0; stc_out_wr_en = 1'b0; stc_done = 1'b0;
    #2 reset_n = 1'b0;
    test_reset();
    test_full_run();
    test_start_errors();
    test_abort();
    test_short();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
